// File: rtl/uart_sample_unpacker_if.sv
// Bus bundle for uart_sample_unpacker: multi-pop FIFO head on one side, sample stream on the other.
// master = the unpacker, slave = FIFO plus downstream consumer.
interface uart_sample_unpacker_if #(
   parameter int N = 4
);
   logic [N-1:0][7:0]      fifo_data;
   logic [$clog2(N+1)-1:0] fifo_can_pop;
   logic [$clog2(N+1)-1:0] fifo_pop;
   logic [15:0]            out_data;
   logic                   out_valid;
   logic                   out_ready;
   logic                   out_first;
   logic                   out_last;

   modport master (
      input  fifo_data, fifo_can_pop, out_ready,
      output fifo_pop, out_data, out_valid, out_first, out_last
   );

   modport slave (
      output fifo_data, fifo_can_pop, out_ready,
      input  fifo_pop, out_data, out_valid, out_first, out_last
   );
endinterface

// File: rtl/uart_sample_unpacker.sv
// Hunts for SYNC_BYTE in the UART RX FIFO, then unpacks FRAME_LEN little-endian 16-bit samples.
// Define UART_UNPACK_CHECKSUM_EN to check a trailing XOR byte after each frame.
module uart_sample_unpacker #(
   parameter int         N         = 4,
   parameter int         FRAME_LEN = 256,
   parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
   input  logic                  clk,
   input  logic                  rstn,
   uart_sample_unpacker_if.master bus,
   output logic                  sync_drop,
   output logic                  chk_err
);
   localparam int PW = $clog2(N + 1);
   localparam int CW = $clog2(FRAME_LEN + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_LEN - 1);

`ifdef UART_UNPACK_CHECKSUM_EN
   typedef enum logic [1:0] {HUNT = 2'd0, PAYLOAD = 2'd1, CHECK = 2'd2} state_t;
`else
   typedef enum logic {HUNT = 1'b0, PAYLOAD = 1'b1} state_t;
`endif

   state_t        state, state_nxt;
   logic [CW-1:0] cnt_p0;
   logic [15:0]   data_p1;
   logic          vld_p1, first_p1, last_p1;
   logic          slot_free, has1, has2, sync_hit, load_p0, frame_end;

   assign slot_free = !vld_p1 || bus.out_ready;
   assign has1      = bus.fifo_can_pop >= PW'(1);
   assign has2      = bus.fifo_can_pop >= PW'(2);
   assign sync_hit  = (state == HUNT) && has1 && (bus.fifo_data[0] == SYNC_BYTE);
   // A sample is only taken when both of its bytes are present and the output slot can accept it.
   assign load_p0   = (state == PAYLOAD) && has2 && slot_free;
   assign frame_end = load_p0 && (cnt_p0 == CNT_LAST);

   always_ff @(posedge clk) begin
      if (!rstn) state <= HUNT;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         HUNT:    if (sync_hit) state_nxt = PAYLOAD;
`ifdef UART_UNPACK_CHECKSUM_EN
         PAYLOAD: if (frame_end) state_nxt = CHECK;
         CHECK:   if (has1) state_nxt = HUNT;
`else
         PAYLOAD: if (frame_end) state_nxt = HUNT;
`endif
         default: state_nxt = HUNT;
      endcase
   end

   always_comb begin
      bus.fifo_pop = '0;
      if (rstn) begin
         case (state)
            HUNT:    if (has1) bus.fifo_pop = PW'(1);
            PAYLOAD: if (load_p0) bus.fifo_pop = PW'(2);
`ifdef UART_UNPACK_CHECKSUM_EN
            CHECK:   if (has1) bus.fifo_pop = PW'(1);
`endif
            default: bus.fifo_pop = '0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn)         cnt_p0 <= '0;
      else if (sync_hit) cnt_p0 <= '0;
      else if (load_p0)  cnt_p0 <= frame_end ? '0 : cnt_p0 + CW'(1);
   end

   // ---- stage p0 -> p1: single-entry output register ----
   always_ff @(posedge clk) begin
      if (!rstn) begin
         vld_p1   <= 1'b0;
         data_p1  <= '0;
         first_p1 <= 1'b0;
         last_p1  <= 1'b0;
      end else if (load_p0) begin
         vld_p1   <= 1'b1;
         data_p1  <= {bus.fifo_data[1], bus.fifo_data[0]};
         first_p1 <= (cnt_p0 == '0);
         last_p1  <= (cnt_p0 == CNT_LAST);
      end else if (slot_free) begin
         vld_p1   <= 1'b0;
      end
   end

   assign bus.out_valid = vld_p1;
   assign bus.out_data  = data_p1;
   assign bus.out_first = first_p1;
   assign bus.out_last  = last_p1;

   always_ff @(posedge clk) begin
      if (!rstn) sync_drop <= 1'b0;
      else       sync_drop <= (state == HUNT) && has1 && (bus.fifo_data[0] != SYNC_BYTE);
   end

`ifdef UART_UNPACK_CHECKSUM_EN
   logic [7:0] xor_p0;

   // Running XOR is a datapath register: cleared when the sync byte is accepted, not by reset.
   always_ff @(posedge clk) begin
      if (sync_hit)     xor_p0 <= 8'h00;
      else if (load_p0) xor_p0 <= xor_p0 ^ bus.fifo_data[0] ^ bus.fifo_data[1];
   end

   always_ff @(posedge clk) begin
      if (!rstn) chk_err <= 1'b0;
      else       chk_err <= (state == CHECK) && has1 && (bus.fifo_data[0] != xor_p0);
   end
`else
   assign chk_err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_sample_unpacker.sv
// Directed bench for uart_sample_unpacker (N=4, FRAME_LEN=4) with a byte-queue FIFO model.
// Checksum scenarios run when UART_UNPACK_CHECKSUM_EN is defined.
module tb_uart_sample_unpacker;
   localparam int N  = 4;
   localparam int FL = 4;
   localparam int PW = $clog2(N + 1);

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   logic sync_drop, chk_err;
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   uart_sample_unpacker_if #(.N(N)) bus ();

   uart_sample_unpacker #(.N(N), .FRAME_LEN(FL), .SYNC_BYTE(8'hA5)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .bus       (bus),
      .sync_drop (sync_drop),
      .chk_err   (chk_err)
   );

   // FIFO model: bytes in mem[rd..wr-1], at most N visible, flushed by rstn like the real FIFO
   logic [7:0]  mem [0:1023];
   int          wr = 0, rd = 0, cyc = 0, drops = 0, errs = 0;
   logic [15:0] cap_d [$];
   bit          cap_f [$];
   bit          cap_l [$];
   int          cap_t [$];

   always_comb begin
      int avail;
      avail = wr - rd;
      if (avail > N) avail = N;
      bus.fifo_can_pop = PW'(avail);
      for (int i = 0; i < N; i++) bus.fifo_data[i] = mem[(rd + i) & 1023];
   end

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!rstn) rd <= wr;
      else       rd <= rd + int'(bus.fifo_pop);
   end

   always @(negedge clk) begin
      if (rstn && bus.out_valid && bus.out_ready) begin
         cap_d.push_back(bus.out_data);
         cap_f.push_back(bus.out_first);
         cap_l.push_back(bus.out_last);
         cap_t.push_back(cyc);
      end
      if (sync_drop) drops = drops + 1;
      if (chk_err)   errs  = errs + 1;
   end

   function automatic logic [15:0] smp(input logic [15:0] s0, input logic [15:0] step, input int k);
      return s0 + step * 16'(k);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] b);
      mem[wr & 1023] = b;
      wr = wr + 1;
   endtask

   task automatic push_frame(input logic [15:0] s0, input logic [15:0] step, input bit bad_ck);
      logic [7:0]  x;
      logic [15:0] v;
      x = 8'h00;
      push(8'hA5);
      for (int k = 0; k < FL; k++) begin
         v = smp(s0, step, k);
         push(v[7:0]);
         push(v[15:8]);
         x = x ^ v[7:0] ^ v[15:8];
      end
`ifdef UART_UNPACK_CHECKSUM_EN
      push(bad_ck ? (x ^ 8'h01) : x);
`endif
   endtask

   task automatic wait_caps(input int target, input int budget);
      int b;
      b = 0;
      while (cap_d.size() < target && b < budget) begin
         @(posedge clk);
         b++;
      end
      #1;
   endtask

   task automatic test_reset();
      bus.out_ready = 1'b1;
      rstn = 1'b0;
      repeat (2) tick();
      push(8'h11);
      @(negedge clk);
      tests++;
      if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", bus.out_valid); end
      tests++;
      if (bus.out_data !== 16'h0000) begin fails++; $display("FAIL reset_data got %h want 0000", bus.out_data); end
      tests++;
      if ({bus.out_first, bus.out_last, sync_drop, chk_err} !== 4'b0000)
         begin fails++; $display("FAIL reset_flags got %b want 0000", {bus.out_first, bus.out_last, sync_drop, chk_err}); end
      tests++;
      if (bus.fifo_pop !== PW'(0)) begin fails++; $display("FAIL reset_pop got %0d want 0", bus.fifo_pop); end
      @(posedge clk);
      #1;
      rstn = 1'b1;
      repeat (3) tick();
      tests++;
      if (drops !== 0) begin fails++; $display("FAIL reset_flush_drops got %0d want 0", drops); end
   endtask

   task automatic test_basic();
      int base, d0;
      base = cap_d.size();
      d0 = drops;
      push_frame(16'h0001, 16'h0001, 1'b0);
      wait_caps(base + FL, 60);
      tests++;
      if (cap_d.size() != base + FL) begin fails++; $display("FAIL basic_count got %0d want %0d", cap_d.size() - base, FL); end
      else for (int k = 0; k < FL; k++) begin
         tests++;
         if (cap_d[base+k] !== smp(16'h0001, 16'h0001, k) || cap_f[base+k] !== (k == 0) || cap_l[base+k] !== (k == FL-1)) begin
            fails++;
            $display("FAIL basic_sample%0d got %h f%0b l%0b want %h f%0b l%0b", k, cap_d[base+k], cap_f[base+k], cap_l[base+k],
                     smp(16'h0001, 16'h0001, k), k == 0, k == FL-1);
         end
      end
      repeat (3) tick();
      tests++;
      if (drops != d0) begin fails++; $display("FAIL basic_sync_drop got %0d want 0", drops - d0); end
   endtask

   task automatic test_hunt();
      int base, d0;
      base = cap_d.size();
      d0 = drops;
      push(8'h11);
      push(8'h22);
      push_frame(16'hBEEF, 16'h0102, 1'b0);
      wait_caps(base + FL, 60);
      tests++;
      if (drops - d0 != 2) begin fails++; $display("FAIL hunt_drops got %0d want 2", drops - d0); end
      tests++;
      if (cap_d.size() != base + FL) begin fails++; $display("FAIL hunt_count got %0d want %0d", cap_d.size() - base, FL); end
      else for (int k = 0; k < FL; k++) begin
         tests++;
         if (cap_d[base+k] !== smp(16'hBEEF, 16'h0102, k) || cap_f[base+k] !== (k == 0) || cap_l[base+k] !== (k == FL-1)) begin
            fails++;
            $display("FAIL hunt_sample%0d got %h f%0b l%0b want %h", k, cap_d[base+k], cap_f[base+k], cap_l[base+k],
                     smp(16'hBEEF, 16'h0102, k));
         end
      end
   endtask

   task automatic test_back_to_back();
      int base, d0;
      logic [15:0] s0, st;
      base = cap_d.size();
      d0 = drops;
      push_frame(16'h12A5, 16'h0101, 1'b0);
      push_frame(16'hA5A5, 16'hFFFF, 1'b0);
      wait_caps(base + 2*FL, 80);
      tests++;
      if (cap_d.size() != base + 2*FL) begin fails++; $display("FAIL b2b_count got %0d want %0d", cap_d.size() - base, 2*FL); end
      else begin
         for (int k = 0; k < 2*FL; k++) begin
            s0 = (k < FL) ? 16'h12A5 : 16'hA5A5;
            st = (k < FL) ? 16'h0101 : 16'hFFFF;
            tests++;
            if (cap_d[base+k] !== smp(s0, st, k % FL) || cap_f[base+k] !== (k % FL == 0) || cap_l[base+k] !== (k % FL == FL-1)) begin
               fails++;
               $display("FAIL b2b_sample%0d got %h f%0b l%0b want %h", k, cap_d[base+k], cap_f[base+k], cap_l[base+k], smp(s0, st, k % FL));
            end
         end
         tests++;
         if (cap_t[base+FL-1] - cap_t[base] != FL-1)
            begin fails++; $display("FAIL b2b_rate1 got %0d cycles want %0d", cap_t[base+FL-1] - cap_t[base], FL-1); end
         tests++;
         if (cap_t[base+2*FL-1] - cap_t[base+FL] != FL-1)
            begin fails++; $display("FAIL b2b_rate2 got %0d cycles want %0d", cap_t[base+2*FL-1] - cap_t[base+FL], FL-1); end
      end
      tests++;
      if (drops != d0) begin fails++; $display("FAIL b2b_sync_in_payload drops got %0d want 0", drops - d0); end
   endtask

   task automatic test_stall();
      int base;
      base = cap_d.size();
      push_frame(16'h0100, 16'h0100, 1'b0);
      wait_caps(base + 2, 40);
      tests++;
      if (cap_d.size() != base + 2) begin fails++; $display("FAIL stall_prefix got %0d want 2", cap_d.size() - base); end
      bus.out_ready = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         tests++;
         if (bus.out_valid !== 1'b1 || bus.out_data !== smp(16'h0100, 16'h0100, 2) || bus.fifo_pop !== PW'(0)) begin
            fails++;
            $display("FAIL stall_hold c%0d got v%b d%h pop%0d want v1 d%h pop0", c, bus.out_valid, bus.out_data, bus.fifo_pop,
                     smp(16'h0100, 16'h0100, 2));
         end
      end
      @(posedge clk);
      #1;
      tests++;
      if (cap_d.size() != base + 2) begin fails++; $display("FAIL stall_no_accept got %0d want 2", cap_d.size() - base); end
      bus.out_ready = 1'b1;
      wait_caps(base + FL, 40);
      repeat (3) tick();
      tests++;
      if (cap_d.size() != base + FL) begin fails++; $display("FAIL stall_count got %0d want %0d", cap_d.size() - base, FL); end
      else for (int k = 0; k < FL; k++) begin
         tests++;
         if (cap_d[base+k] !== smp(16'h0100, 16'h0100, k) || cap_l[base+k] !== (k == FL-1)) begin
            fails++;
            $display("FAIL stall_sample%0d got %h l%0b want %h", k, cap_d[base+k], cap_l[base+k], smp(16'h0100, 16'h0100, k));
         end
      end
   endtask

   task automatic test_trickle();
      int base;
      logic [15:0] v;
      logic [7:0]  b, x;
      base = cap_d.size();
      x = 8'h00;
      push(8'hA5);
      repeat (3) tick();
      for (int j = 0; j < 2*FL; j++) begin
         v = smp(16'h5AC3, 16'h1111, j / 2);
         b = (j % 2 == 0) ? v[7:0] : v[15:8];
         x = x ^ b;
         push(b);
         for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            tests++;
            if (bus.fifo_pop > bus.fifo_can_pop || bus.fifo_pop == PW'(1)) begin
               fails++;
               $display("FAIL trickle_pop j%0d c%0d got pop%0d can%0d want 0 or 2 within can", j, c, bus.fifo_pop, bus.fifo_can_pop);
            end
            @(posedge clk);
         end
         #1;
         tests++;
         if (cap_d.size() - base != (j + 1) / 2)
            begin fails++; $display("FAIL trickle_emit j%0d got %0d want %0d", j, cap_d.size() - base, (j + 1) / 2); end
      end
`ifdef UART_UNPACK_CHECKSUM_EN
      push(x);
`endif
      repeat (3) tick();
      tests++;
      if (cap_d.size() != base + FL) begin fails++; $display("FAIL trickle_count got %0d want %0d", cap_d.size() - base, FL); end
      else for (int k = 0; k < FL; k++) begin
         tests++;
         if (cap_d[base+k] !== smp(16'h5AC3, 16'h1111, k) || cap_f[base+k] !== (k == 0) || cap_l[base+k] !== (k == FL-1)) begin
            fails++;
            $display("FAIL trickle_sample%0d got %h want %h", k, cap_d[base+k], smp(16'h5AC3, 16'h1111, k));
         end
      end
   endtask

   task automatic test_checksum();
`ifdef UART_UNPACK_CHECKSUM_EN
      int base, e0, d0;
      e0 = errs;
      d0 = drops;
      base = cap_d.size();
      push_frame(16'h0201, 16'h0202, 1'b0);
      wait_caps(base + FL, 60);
      repeat (4) tick();
      tests++;
      if (errs != e0) begin fails++; $display("FAIL chk_good got %0d pulses want 0", errs - e0); end
      push_frame(16'h0201, 16'h0202, 1'b1);
      wait_caps(base + 2*FL, 60);
      repeat (4) tick();
      tests++;
      if (errs - e0 != 1) begin fails++; $display("FAIL chk_bad got %0d pulses want 1", errs - e0); end
      tests++;
      if (cap_d.size() != base + 2*FL) begin fails++; $display("FAIL chk_bad_samples got %0d want %0d", cap_d.size() - base, 2*FL); end
      base = cap_d.size();
      push_frame(16'h1357, 16'h0001, 1'b0);
      wait_caps(base + FL, 60);
      repeat (4) tick();
      tests++;
      if (cap_d.size() != base + FL || cap_d[base] !== 16'h1357 || cap_f[base] !== 1'b1)
         begin fails++; $display("FAIL chk_rehunt got %0d samples first %h want %0d samples first 1357", cap_d.size() - base, cap_d[base], FL); end
      tests++;
      if (drops != d0) begin fails++; $display("FAIL chk_byte_dropped got %0d drops want 0", drops - d0); end
`else
      repeat (2) tick();
      tests++;
      if (errs != 0 || chk_err !== 1'b0) begin fails++; $display("FAIL chk_tied got %0d pulses now %b want 0", errs, chk_err); end
`endif
   endtask

   task automatic test_reset_mid();
      int base;
      base = cap_d.size();
      push_frame(16'h0F00, 16'h0011, 1'b0);
      wait_caps(base + 3, 40);
      tests++;
      if (cap_d.size() != base + 3) begin fails++; $display("FAIL rstmid_prefix got %0d want 3", cap_d.size() - base); end
      bus.out_ready = 1'b0;
      rstn = 1'b0;
      @(posedge clk);
      @(negedge clk);
      tests++;
      if (bus.out_valid !== 1'b0 || bus.out_data !== 16'h0000 || bus.out_last !== 1'b0)
         begin fails++; $display("FAIL rstmid_drop got v%b d%h l%b want v0 d0000 l0", bus.out_valid, bus.out_data, bus.out_last); end
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      rstn = 1'b1;
      repeat (4) tick();
      tests++;
      if (cap_d.size() != base + 3) begin fails++; $display("FAIL rstmid_stale got %0d want 3", cap_d.size() - base); end
      base = cap_d.size();
      push_frame(16'h7001, 16'h0003, 1'b0);
      wait_caps(base + FL, 60);
      tests++;
      if (cap_d.size() != base + FL) begin fails++; $display("FAIL rstmid_count got %0d want %0d", cap_d.size() - base, FL); end
      else for (int k = 0; k < FL; k++) begin
         tests++;
         if (cap_d[base+k] !== smp(16'h7001, 16'h0003, k) || cap_f[base+k] !== (k == 0) || cap_l[base+k] !== (k == FL-1)) begin
            fails++;
            $display("FAIL rstmid_sample%0d got %h f%0b l%0b want %h", k, cap_d[base+k], cap_f[base+k], cap_l[base+k],
                     smp(16'h7001, 16'h0003, k));
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
      bus.out_ready = 1'b1;
      test_reset();
      test_basic();
      test_hunt();
      test_back_to_back();
      test_stall();
      test_trickle();
      test_checksum();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, %0d tests run", tests);
      $fatal(1, "watchdog");
   end
endmodule
